// File: rtl/ex_hazard_ctrl_if.sv
// ID-to-hazard-controller bundle: decoded operand/dest info in,
// stall/bubble and EX operand forward selects out.
interface ex_hazard_ctrl_if #(
  parameter int REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_we;
  logic              id_load;
  logic              id_muldiv;
  logic              flush;
  logic              stall;
  logic              bubble;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;

  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    output id_dst, id_we, id_load, id_muldiv, flush,
    input  stall, bubble, fwd_a_sel, fwd_b_sel
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
    input  id_dst, id_we, id_load, id_muldiv, flush,
    output stall, bubble, fwd_a_sel, fwd_b_sel
  );
endinterface

// File: rtl/ex_hazard_ctrl.sv
// EX-stage hazard/forwarding controller (load-use stall, ALU A/B selects).
// Define EX_HAZARD_MULDIV_STALL_EN to stall ID while a mult/div occupies EX.
module ex_hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MULDIV_LAT = 4
) (
  input logic              clk,
  input logic              rst,
  ex_hazard_ctrl_if.slave  bus
);

  logic [REG_AW-1:0] r_ex_dst;
  logic              r_ex_we;
  logic              r_ex_load;
  logic [REG_AW-1:0] r_mem_dst;
  logic              r_mem_we;
  logic [REG_AW-1:0] r_wb_dst;
  logic              r_wb_we;
  logic [1:0]        r_fwd_a;
  logic [1:0]        r_fwd_b;

  logic              w_hit_rs;
  logic              w_hit_rt;
  logic              w_hazard;
  logic              w_md_stall;
  logic              w_stall;
  logic              w_enter;
  logic [1:0]        w_sel_a;
  logic [1:0]        w_sel_b;

  function automatic logic [1:0] f_sel(
    input logic              use_r,
    input logic [REG_AW-1:0] r,
    input logic [REG_AW-1:0] ex_dst,
    input logic              ex_we,
    input logic              ex_load,
    input logic [REG_AW-1:0] mem_dst,
    input logic              mem_we
  );
    logic [1:0] s;
    s = 2'b00;
    if (use_r && r != '0) begin
      if (ex_we && !ex_load && r == ex_dst)
        s = 2'b01;
      else if (mem_we && r == mem_dst)
        s = 2'b10;
    end
    return s;
  endfunction

  assign w_hit_rs = bus.id_use_rs && (bus.id_rs == r_ex_dst);
  assign w_hit_rt = bus.id_use_rt && (bus.id_rt == r_ex_dst);
  assign w_hazard = bus.id_valid && r_ex_load && r_ex_we &&
                    (r_ex_dst != '0) && (w_hit_rs || w_hit_rt);

`ifdef EX_HAZARD_MULDIV_STALL_EN
  logic [2:0] r_busy;

  assign w_md_stall = bus.id_valid && (r_busy != 3'd0);

  // Flush does not clear the countdown; the unit is still busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_busy <= 3'd0;
    else if (w_enter && bus.id_muldiv)
      r_busy <= 3'(MULDIV_LAT - 1);
    else if (r_busy != 3'd0)
      r_busy <= r_busy - 3'd1;
  end
`else
  logic [3:0] w_unused_md;

  assign w_md_stall  = 1'b0;
  assign w_unused_md = {bus.id_muldiv, 3'(MULDIV_LAT)};
`endif

  // Flush wins over any stall source
  assign w_stall = (w_hazard || w_md_stall) && !bus.flush;
  assign w_enter = bus.id_valid && !w_stall && !bus.flush;

  assign w_sel_a = f_sel(bus.id_use_rs, bus.id_rs, r_ex_dst,
                         r_ex_we, r_ex_load, r_mem_dst, r_mem_we);
  assign w_sel_b = f_sel(bus.id_use_rt, bus.id_rt, r_ex_dst,
                         r_ex_we, r_ex_load, r_mem_dst, r_mem_we);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_dst  <= '0;
      r_ex_we   <= 1'b0;
      r_ex_load <= 1'b0;
      r_mem_dst <= '0;
      r_mem_we  <= 1'b0;
      r_wb_dst  <= '0;
      r_wb_we   <= 1'b0;
      r_fwd_a   <= 2'b00;
      r_fwd_b   <= 2'b00;
    end else begin
      r_wb_dst  <= r_mem_dst;
      r_wb_we   <= r_mem_we;
      r_mem_dst <= r_ex_dst;
      r_mem_we  <= r_ex_we;
      if (w_enter) begin
        r_ex_dst  <= bus.id_dst;
        r_ex_we   <= bus.id_we;
        r_ex_load <= bus.id_load;
        r_fwd_a   <= w_sel_a;
        r_fwd_b   <= w_sel_b;
      end else begin
        r_ex_dst  <= '0;
        r_ex_we   <= 1'b0;
        r_ex_load <= 1'b0;
        r_fwd_a   <= 2'b00;
        r_fwd_b   <= 2'b00;
      end
    end
  end

  // WB slot is debug-only: the register file is write-through
  logic [REG_AW:0] w_unused_wb;
  assign w_unused_wb = {r_wb_dst, r_wb_we};

  assign bus.stall     = w_stall;
  assign bus.bubble    = w_stall;
  assign bus.fwd_a_sel = r_fwd_a;
  assign bus.fwd_b_sel = r_fwd_b;

endmodule
